// File: rtl/mole_game_n_if.sv
// Player-facing signal bundle for the whack-a-mole game core.
interface mole_game_n_if #(
  parameter int N_HOLES = 16,
  parameter int SCORE_W = 12,
  parameter int CD_W    = 10
);
  logic               game_start_i;
  logic               pause_i;
  logic [31:0]        seed_i;
  logic [N_HOLES-1:0] hit_i;
  logic [N_HOLES-1:0] good_mole_o;
  logic [N_HOLES-1:0] bad_mole_o;
  logic [CD_W-1:0]    countdown_o;
  logic [SCORE_W-1:0] score_o;
  logic [SCORE_W-1:0] high_score_o;
  logic [2:0]         combo_o;
  logic [2:0]         state_o;
  logic               game_over_o;

  modport master (
    output game_start_i, pause_i, seed_i, hit_i,
    input  good_mole_o, bad_mole_o, countdown_o, score_o, high_score_o,
           combo_o, state_o, game_over_o
  );

  modport slave (
    input  game_start_i, pause_i, seed_i, hit_i,
    output good_mole_o, bad_mole_o, countdown_o, score_o, high_score_o,
           combo_o, state_o, game_over_o
  );
endinterface

// File: rtl/mole_game_n.sv
// Whack-a-mole game core: tick divider, LFSR mole spawner, per-hole life
// counters, hit scoring with combo multiplier and high-score tracking.

// One hole: occupancy (good/bad) and remaining life in ticks.
module mole_game_n_hole #(
  parameter int LIFE_W    = 4,
  parameter int MOLE_LIFE = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic tick_i,
  input  logic hit_i,
  input  logic spawn_good_i,
  input  logic spawn_bad_i,
  output logic good_o,
  output logic bad_o,
  output logic expire_good_o
);
  logic              good_q, good_d, bad_q, bad_d;
  logic [LIFE_W-1:0] life_q, life_d;
  logic              occ, last;

  assign occ  = good_q | bad_q;
  assign last = (life_q == LIFE_W'(1));
  // A hit consumes the mole before it can expire, so it never resets combo.
  assign expire_good_o = tick_i & good_q & last & ~hit_i;
  assign good_o = good_q;
  assign bad_o  = bad_q;

  // Next hole contents: clear > spawn > hit > ageing.
  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    life_d = life_q;
    if (clr_i) begin
      good_d = 1'b0;
      bad_d  = 1'b0;
      life_d = '0;
    end else if (tick_i && (spawn_good_i || spawn_bad_i)) begin
      good_d = spawn_good_i;
      bad_d  = ~spawn_good_i;
      life_d = LIFE_W'(MOLE_LIFE);
    end else if (hit_i) begin
      good_d = 1'b0;
      bad_d  = 1'b0;
      life_d = '0;
    end else if (tick_i && occ) begin
      life_d = life_q - LIFE_W'(1);
      if (last) begin
        good_d = 1'b0;
        bad_d  = 1'b0;
      end
    end
  end

  // Hole state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      good_q <= 1'b0;
      bad_q  <= 1'b0;
      life_q <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
      life_q <= life_d;
    end
  end
endmodule

module mole_game_n #(
  parameter int N_HOLES   = 16,
  parameter int SCORE_W   = 12,
  parameter int CD_W      = 10,
  parameter int PREP_TIME = 5,
  parameter int GAME_TIME = 30,
  parameter int TICK_DIV  = 10,
  parameter int MOLE_LIFE = 8,
  parameter int GOOD_PTS  = 10,
  parameter int BAD_PTS   = 5,
  parameter int COMBO_MAX = 4
) (
  input logic          clk_i,
  input logic          rst_n_i,
  mole_game_n_if.slave bus
);
  localparam int IDX_W  = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LIFE_W = $clog2(MOLE_LIFE + 1);
  localparam int SUM_W  = SCORE_W + 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PREP = 3'd1, S_PLAY = 3'd2, S_PAUSED = 3'd3, S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic [SCORE_W-1:0] score_q, score_d, hs_q, hs_d;
  logic [2:0]         combo_q, combo_d;
  logic [31:0]        lfsr_q, lfsr_d, lfsr_nx;
  logic               go_q;
  logic [N_HOLES-1:0] hit_q, hit_prev_q, edge_v, hit_sel;
  logic [N_HOLES-1:0] good_v, bad_v, expire_good, spawn_g, spawn_b;
  logic               tick, play_go, play_tick, end_tick, start, clr_holes;
  logic               hit_any, hit_good, hit_bad;
  logic [IDX_W-1:0]   g_idx, b_idx;
  logic [SUM_W-1:0]   sum_w;
  logic [SCORE_W-1:0] score_add, score_sub;

  // Control decode kept outside the FSM block so hole feedback (expiry) has no loop.
  assign tick      = (div_q == DIV_W'(TICK_DIV - 1));
  assign play_go   = (state_q == S_PLAY) && !bus.pause_i;
  assign play_tick = play_go && tick && (cd_q != '0);
  assign end_tick  = play_go && tick && (cd_q == '0);
  assign start     = (state_q == S_IDLE) && bus.game_start_i;
  assign clr_holes = start | end_tick;

  // Rising edges of the registered buttons; only the lowest one survives.
  assign edge_v   = hit_q & ~hit_prev_q;
  assign hit_sel  = play_go ? (edge_v & (~edge_v + N_HOLES'(1))) : '0;
  assign hit_any  = |hit_sel;
  assign hit_good = |(hit_sel & good_v);
  assign hit_bad  = |(hit_sel & bad_v);

  // Galois LFSR, taps 32,22,2,1; spawns use the freshly stepped value.
  assign lfsr_nx = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
  assign g_idx   = IDX_W'(lfsr_nx[15:0] % 16'(N_HOLES));
  assign b_idx   = IDX_W'(lfsr_nx[31:16] % 16'(N_HOLES));
  assign spawn_g = N_HOLES'(1) << g_idx;
  assign spawn_b = (b_idx != g_idx) ? (N_HOLES'(1) << b_idx) : '0;

  assign sum_w     = SUM_W'(score_q) + SUM_W'(GOOD_PTS * int'(combo_q));
  assign score_add = (sum_w > SUM_W'({SCORE_W{1'b1}})) ? '1 : sum_w[SCORE_W-1:0];
  assign score_sub = (score_q >= SCORE_W'(BAD_PTS)) ? score_q - SCORE_W'(BAD_PTS) : '0;

  for (genvar h = 0; h < N_HOLES; h++) begin : g_hole
    mole_game_n_hole #(.LIFE_W(LIFE_W), .MOLE_LIFE(MOLE_LIFE)) u_hole (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .clr_i         (clr_holes),
      .tick_i        (play_tick),
      .hit_i         (hit_sel[h]),
      .spawn_good_i  (spawn_g[h]),
      .spawn_bad_i   (spawn_b[h]),
      .good_o        (good_v[h]),
      .bad_o         (bad_v[h]),
      .expire_good_o (expire_good[h])
    );
  end

  // Game FSM next state and datapath updates.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cd_d    = cd_q;
    score_d = score_q;
    hs_d    = hs_q;
    combo_d = combo_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.game_start_i) begin
          lfsr_d  = (bus.seed_i == 32'h0) ? 32'h1 : bus.seed_i;
          score_d = '0;
          div_d   = '0;
          combo_d = 3'd1;
          cd_d    = CD_W'(PREP_TIME);
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          if (cd_q == '0) begin
            cd_d    = CD_W'(GAME_TIME);
            state_d = S_PLAY;
          end else begin
            cd_d = cd_q - CD_W'(1);
          end
        end
      end
      S_PLAY: begin
        if (bus.pause_i) begin
          state_d = S_PAUSED;
        end else begin
          div_d = tick ? '0 : div_q + DIV_W'(1);
          if (hit_good) begin
            score_d = score_add;
            combo_d = (combo_q < 3'(COMBO_MAX)) ? combo_q + 3'd1 : combo_q;
          end else if (hit_any) begin
            if (hit_bad) score_d = score_sub;
            combo_d = 3'd1;
          end
          // Expiry of an unhit good mole overrides any combo gain this cycle.
          if (tick) begin
            if (cd_q == '0) begin
              state_d = S_DONE;
            end else begin
              lfsr_d = lfsr_nx;
              cd_d   = cd_q - CD_W'(1);
              if (|expire_good) combo_d = 3'd1;
            end
          end
        end
      end
      S_PAUSED: begin
        if (!bus.pause_i) state_d = S_PLAY;
      end
      S_DONE: begin
        if (score_q > hs_q) hs_d = score_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Game state registers; Game_over marks the single DONE cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cd_q    <= '0;
      score_q <= '0;
      hs_q    <= '0;
      combo_q <= 3'd1;
      lfsr_q  <= 32'h1;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cd_q    <= cd_d;
      score_q <= score_d;
      hs_q    <= hs_d;
      combo_q <= combo_d;
      lfsr_q  <= lfsr_d;
      go_q    <= (state_d == S_DONE);
    end
  end

  // Button sampling stage and its one-cycle history for edge detection.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hit_q      <= '0;
      hit_prev_q <= '0;
    end else begin
      hit_q      <= bus.hit_i;
      hit_prev_q <= hit_q;
    end
  end

  assign bus.good_mole_o  = good_v;
  assign bus.bad_mole_o   = bad_v;
  assign bus.countdown_o  = cd_q;
  assign bus.score_o      = score_q;
  assign bus.high_score_o = hs_q;
  assign bus.combo_o      = combo_q;
  assign bus.state_o      = state_q;
  assign bus.game_over_o  = go_q;
endmodule

// File: tb/tb_mole_game_n.sv
// Random-play bench: a rule-level game model predicts every cycle's outputs,
// the driver queues predictions, a monitor pops and compares at negedge.
module tb_mole_game_n;
  localparam int NH = 16;
  localparam int PREP = 5, GT = 30, TD = 10, LIFE = 8, GP = 10, BP = 5, CMAX = 4;
  localparam int MAXA = 4095, MAXB = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic game_start = 1'b0, pause = 1'b0;
  logic [31:0] seed = '0;
  logic [NH-1:0] hit = '0;

  always #5 clk = ~clk;

  mole_game_n_if #(.N_HOLES(NH), .SCORE_W(12), .CD_W(10)) bus_a ();
  mole_game_n_if #(.N_HOLES(NH), .SCORE_W(8),  .CD_W(10)) bus_b ();

  assign bus_a.game_start_i = game_start;
  assign bus_a.pause_i      = pause;
  assign bus_a.seed_i       = seed;
  assign bus_a.hit_i        = hit;
  assign bus_b.game_start_i = game_start;
  assign bus_b.pause_i      = pause;
  assign bus_b.seed_i       = seed;
  assign bus_b.hit_i        = hit;

  mole_game_n dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(bus_a));
  mole_game_n #(.SCORE_W(8)) dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(bus_b));

  typedef struct {
    int st, cd, sa, hsa, sb, hsb, combo;
    bit [NH-1:0] good, bad;
    bit go;
  } snap_t;
  snap_t expq[$];

  int n_checks = 0, n_fail = 0, go_exp = 0, go_act = 0;

  // Reference game: phase 0..4 = idle/prep/play/paused/done; kind 0 empty, 1 good, 2 bad.
  int m_st, m_div, m_cd, m_sa, m_sb, m_hsa, m_hsb, m_combo;
  bit [31:0] m_lfsr;
  bit m_go;
  int kind[NH];
  int life[NH];
  bit [NH-1:0] h1, h2;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic clear_holes();
    for (int i = 0; i < NH; i++) begin kind[i] = 0; life[i] = 0; end
  endtask

  task automatic play_cycle(input bit [NH-1:0] edges);
    int hk = -1;
    int g, b;
    for (int i = 0; i < NH; i++) if (edges[i] && hk < 0) hk = i;
    if (hk >= 0) begin
      if (kind[hk] == 1) begin
        m_sa = imin(m_sa + GP * m_combo, MAXA);
        m_sb = imin(m_sb + GP * m_combo, MAXB);
        m_combo = imin(m_combo + 1, CMAX);
      end else begin
        if (kind[hk] == 2) begin
          m_sa = (m_sa > BP) ? m_sa - BP : 0;
          m_sb = (m_sb > BP) ? m_sb - BP : 0;
        end
        m_combo = 1;
      end
      kind[hk] = 0;
    end
    if (m_div == TD - 1) begin
      m_div = 0;
      if (m_cd == 0) begin
        m_st = 4;
        clear_holes();
      end else begin
        if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 32'h8020_0003;
        else m_lfsr = m_lfsr >> 1;
        for (int i = 0; i < NH; i++) begin
          if (kind[i] != 0) begin
            life[i]--;
            if (life[i] == 0) begin
              if (kind[i] == 1) m_combo = 1;
              kind[i] = 0;
            end
          end
        end
        g = int'(m_lfsr[15:0]) % NH;
        b = int'(m_lfsr[31:16]) % NH;
        kind[g] = 1; life[g] = LIFE;
        if (b != g) begin kind[b] = 2; life[b] = LIFE; end
        m_cd--;
      end
    end else begin
      m_div++;
    end
  endtask

  task automatic model_step(input bit rs, input bit gs, input bit ps,
                            input bit [31:0] sd, input bit [NH-1:0] ht);
    snap_t e;
    bit [NH-1:0] edges;
    if (!rs) begin
      m_st = 0; m_div = 0; m_cd = 0; m_sa = 0; m_sb = 0; m_hsa = 0; m_hsb = 0;
      m_combo = 1; m_lfsr = 32'h1; m_go = 0; h1 = '0; h2 = '0;
      clear_holes();
    end else begin
      edges = h1 & ~h2;
      case (m_st)
        0: if (gs) begin
          m_lfsr = (sd == 0) ? 32'h1 : sd;
          m_sa = 0; m_sb = 0; m_div = 0; m_combo = 1; m_cd = PREP; m_st = 1;
          clear_holes();
        end
        1: begin
          if (m_div == TD - 1) begin
            m_div = 0;
            if (m_cd == 0) begin m_cd = GT; m_st = 2; end
            else m_cd--;
          end else m_div++;
        end
        2: if (ps) m_st = 3; else play_cycle(edges);
        3: if (!ps) m_st = 2;
        default: begin
          if (m_sa > m_hsa) m_hsa = m_sa;
          if (m_sb > m_hsb) m_hsb = m_sb;
          m_st = 0;
        end
      endcase
      m_go = (m_st == 4);
      h2 = h1;
      h1 = ht;
    end
    if (m_go) go_exp++;
    e.st = m_st; e.cd = m_cd; e.sa = m_sa; e.hsa = m_hsa; e.sb = m_sb; e.hsb = m_hsb;
    e.combo = m_combo; e.go = m_go;
    for (int i = 0; i < NH; i++) begin
      e.good[i] = (kind[i] == 1);
      e.bad[i]  = (kind[i] == 2);
    end
    expq.push_back(e);
  endtask

  task automatic step(input bit rs, input bit gs, input bit ps,
                      input bit [31:0] sd, input bit [NH-1:0] ht);
    @(negedge clk);
    #1;
    rst_n = rs; game_start = gs; pause = ps; seed = sd; hit = ht;
    model_step(rs, gs, ps, sd, ht);
  endtask

  function automatic bit [NH-1:0] pick(input int k);
    int idx[$];
    bit [NH-1:0] one = 1;
    for (int i = 0; i < NH; i++) if (kind[i] == k) idx.push_back(i);
    if (idx.size() == 0) return '0;
    return one << idx[$urandom_range(0, idx.size() - 1)];
  endfunction

  task automatic play_game(input bit [31:0] sd, input int aggr, input bit pauses, input int abort_at);
    int n = 0, hold = 0, pz = 0, r;
    bit [NH-1:0] ht = '0;
    bit ps, gs;
    step(1, 1, 0, sd, '0);
    while (m_st != 0 && n < 4000) begin
      if (pz > 0) begin pz--; ps = 1; end
      else if (pauses && m_st == 2 && $urandom_range(0, 149) == 0) begin
        pz = $urandom_range(1, 50); ps = 1;
      end
      else if (m_st != 2 && m_st != 3) ps = ($urandom_range(0, 5) == 0);
      else ps = 0;
      gs = ($urandom_range(0, 15) == 0);
      if (hold > 0) hold--;
      else if (ht != 0) ht = '0;
      else begin
        r = $urandom_range(0, 99);
        if (r < aggr) ht = pick(1);
        else if (r < aggr + 10) ht = pick(2);
        else if (r < aggr + 20) ht = NH'($urandom);
        else ht = '0;
        if (ht != 0 && $urandom_range(0, 7) == 0) hold = $urandom_range(1, 20);
      end
      if (abort_at > 0 && n == abort_at) begin
        step(0, 0, 0, $urandom, ht);
        step(0, 0, 0, $urandom, ht);
        return;
      end
      step(1, gs, ps, $urandom, ht);
      n++;
    end
    if (n >= 4000) begin
      n_checks++; n_fail++;
      $display("FAIL game_timeout: model did not return to idle within %0d cycles (phase %0d)", n, m_st);
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++)
      step(1, 0, bit'($urandom_range(0, 1)), $urandom, NH'($urandom_range(0, 3)));
  endtask

  // Monitor: compare every DUT snapshot with the oldest queued prediction.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (bus_a.game_over_o) go_act++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n_checks++;
        if (int'(bus_a.state_o) != e.st || int'(bus_a.countdown_o) != e.cd ||
            int'(bus_a.score_o) != e.sa || int'(bus_a.high_score_o) != e.hsa ||
            int'(bus_b.score_o) != e.sb || int'(bus_b.high_score_o) != e.hsb ||
            int'(bus_a.combo_o) != e.combo || bus_a.good_mole_o != e.good ||
            bus_a.bad_mole_o != e.bad || bus_a.game_over_o != e.go) begin
          n_fail++;
          $display("FAIL snapshot @%0t: got st=%0d cd=%0d sc=%0d hs=%0d sc8=%0d hs8=%0d cb=%0d g=%h b=%h go=%0d | want st=%0d cd=%0d sc=%0d hs=%0d sc8=%0d hs8=%0d cb=%0d g=%h b=%h go=%0d",
                   $time, bus_a.state_o, bus_a.countdown_o, bus_a.score_o, bus_a.high_score_o,
                   bus_b.score_o, bus_b.high_score_o, bus_a.combo_o, bus_a.good_mole_o,
                   bus_a.bad_mole_o, bus_a.game_over_o, e.st, e.cd, e.sa, e.hsa, e.sb, e.hsb,
                   e.combo, e.good, e.bad, e.go);
        end
      end
    end
  end

  // Stimulus: reset, several games of differing style, a mid-game reset abort.
  initial begin
    step(0, 0, 0, '0, '0);
    step(0, 1, 1, 32'h1234, '1);
    idle_cycles(3);
    play_game(32'h0, 75, 0, 0);
    idle_cycles(4);
    play_game($urandom, 15, 1, 0);
    idle_cycles(3);
    play_game($urandom, 50, 1, 0);
    idle_cycles(3);
    play_game($urandom, 60, 0, 200);
    idle_cycles(3);
    play_game($urandom, 40, 1, 0);
    idle_cycles(3);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d predictions left, want 0", expq.size());
    end
    n_checks++;
    if (go_act != go_exp) begin
      n_fail++;
      $display("FAIL game_over_count: got %0d pulses, want %0d", go_act, go_exp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
